// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, stage indices
// and the register-match helper used by hazard detection.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        STG_FETCH  = 2'd0,
        STG_DECODE = 2'd1,
        STG_EXEC   = 2'd2,
        STG_MEM    = 2'd3
    } stage_t;

    localparam int NUM_STG = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic src_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and latch/PC control outputs exchanged
// between the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic             ex_rd_memory;
    logic             ex_is_branch;
    logic             ex_mispredict;
    logic             mem_busy;
    logic             perf_clr;

    logic             pc_ena;
    logic             pc_redirect;
    logic             fetch_stg_ena;
    logic             decode_stg_ena;
    logic             exec_stg_ena;
    logic             mem_stg_ena;
    logic             fetch_stg_x;
    logic             decode_stg_x;
    logic             exec_stg_x;
    logic             mem_stg_x;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_valid, ex_rd, ex_rd_memory, ex_is_branch, ex_mispredict,
               mem_busy, perf_clr,
        input  pc_ena, pc_redirect,
               fetch_stg_ena, decode_stg_ena, exec_stg_ena, mem_stg_ena,
               fetch_stg_x, decode_stg_x, exec_stg_x, mem_stg_x,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_valid, ex_rd, ex_rd_memory, ex_is_branch, ex_mispredict,
               mem_busy, perf_clr,
        output pc_ena, pc_redirect,
               fetch_stg_ena, decode_stg_ena, exec_stg_ena, mem_stg_ena,
               fetch_stg_x, decode_stg_x, exec_stg_x, mem_stg_x,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use and branch-mispredict detection; kept separate so the
// same register-match logic can later drive forwarding decisions.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic       i_ex_valid,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_rd_memory,
    input  logic       i_ex_is_branch,
    input  logic       i_ex_mispredict,
    output logic       o_lu,
    output logic       o_mis
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_ex_load;

    assign w_rs1_hit = src_match(i_id_rs1_used, i_id_rs1, i_ex_rd);
    assign w_rs2_hit = src_match(i_id_rs2_used, i_id_rs2, i_ex_rd);

    // x0 is hardwired to zero, so a load targeting it never blocks a consumer
    assign w_ex_load = i_ex_valid & i_ex_rd_memory & (i_ex_rd != REG_ZERO);

    assign o_lu  = w_ex_load & i_id_valid & (w_rs1_hit | w_rs2_hit);
    assign o_mis = i_ex_valid & i_ex_is_branch & i_ex_mispredict;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives latch hold/bubble
// controls, PC hold/redirect, refetch bubbles and performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int IMEM_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic                  stg_clk,
    input  logic                  reset_n,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int REM_W = $clog2(IMEM_LAT) + 1;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(IMEM_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [REM_W-1:0]   r_rem;
    logic [REM_W-1:0]   w_rem_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               w_lu;
    logic               w_mis;
    logic               w_stall_inc;
    logic               w_flush_inc;
    logic               w_pc_ena;
    logic               w_pc_redirect;
    logic [NUM_STG-1:0] w_ena;
    logic [NUM_STG-1:0] w_x;

    hazard_detect u_hazard_detect (
        .i_id_valid      (bus.id_valid),
        .i_id_rs1        (bus.id_rs1),
        .i_id_rs2        (bus.id_rs2),
        .i_id_rs1_used   (bus.id_rs1_used),
        .i_id_rs2_used   (bus.id_rs2_used),
        .i_ex_valid      (bus.ex_valid),
        .i_ex_rd         (bus.ex_rd),
        .i_ex_rd_memory  (bus.ex_rd_memory),
        .i_ex_is_branch  (bus.ex_is_branch),
        .i_ex_mispredict (bus.ex_mispredict),
        .o_lu            (w_lu),
        .o_mis           (w_mis)
    );

    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Reset is folded in here so the latches are held even before the first edge
    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_ena         = '0;
        w_x           = '0;
        w_pc_ena      = 1'b1;
        w_pc_redirect = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        if (!reset_n) begin
            w_ena    = '1;
            w_pc_ena = 1'b0;
        end else if (bus.mem_busy) begin
            w_ena       = '1;
            w_pc_ena    = 1'b0;
            w_stall_inc = 1'b1;
        end else if (w_mis) begin
            w_x[STG_FETCH]  = 1'b1;
            w_x[STG_DECODE] = 1'b1;
            w_pc_redirect   = 1'b1;
            w_flush_inc     = 1'b1;
            if (IMEM_LAT > 1) begin
                w_state_nxt = ST_REFILL;
                w_rem_nxt   = REM_INIT;
            end else begin
                w_state_nxt = ST_RUN;
                w_rem_nxt   = '0;
            end
        end else if (r_state == ST_REFILL) begin
            w_x[STG_FETCH] = 1'b1;
            if (r_rem <= REM_W'(1)) begin
                w_state_nxt = ST_RUN;
                w_rem_nxt   = '0;
            end else begin
                w_rem_nxt = r_rem - REM_W'(1);
            end
        end else if (w_lu) begin
            // One bubble suffices: the load moves on to MEM at the next edge
            w_ena[STG_FETCH] = 1'b1;
            w_x[STG_DECODE]  = 1'b1;
            w_pc_ena         = 1'b0;
            w_stall_inc      = 1'b1;
        end
    end

    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_cnt <= '0;
        end else if (bus.perf_clr) begin
            r_flush_cnt <= '0;
        end else if (w_flush_inc) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_ena         = w_pc_ena;
    assign bus.pc_redirect    = w_pc_redirect;
    assign bus.fetch_stg_ena  = w_ena[STG_FETCH];
    assign bus.decode_stg_ena = w_ena[STG_DECODE];
    assign bus.exec_stg_ena   = w_ena[STG_EXEC];
    assign bus.mem_stg_ena    = w_ena[STG_MEM];
    assign bus.fetch_stg_x    = w_x[STG_FETCH];
    assign bus.decode_stg_x   = w_x[STG_DECODE];
    assign bus.exec_stg_x     = w_x[STG_EXEC];
    assign bus.mem_stg_x      = w_x[STG_MEM];
    assign bus.stall_cnt      = r_stall_cnt;
    assign bus.flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, corner
// sequences (freeze during refill, reset mid-refill) and a randomized model run.
module tb_pipeline_hazard_ctrl;

    localparam int IMEM_LAT = 3;
    localparam int CNT_W    = 8;

    // Control word: {pc_ena, pc_redirect, ena f/d/e/m, x f/d/e/m}
    localparam logic [9:0] C_NORMAL = 10'b10_0000_0000;
    localparam logic [9:0] C_LU     = 10'b00_1000_0100;
    localparam logic [9:0] C_MIS    = 10'b11_0000_1100;
    localparam logic [9:0] C_REFILL = 10'b10_0000_1000;
    localparam logic [9:0] C_FREEZE = 10'b00_1111_0000;

    typedef struct packed {
        logic       idValid;
        logic [4:0] rs1;
        logic       rs1Used;
        logic [4:0] rs2;
        logic       rs2Used;
        logic       exValid;
        logic [4:0] exRd;
        logic       exLoad;
        logic       exBranch;
        logic       exMis;
        logic       memBusy;
        logic       perfClr;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [9:0] ctl;
        int         stall;
        int         flush;
    } vec_t;

    logic  clk;
    logic  rstN;
    int    total;
    int    bad;
    int    expS;
    int    expF;
    vec_t  vecs[$];
    stim_t idleS;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipeline_hazard_ctrl #(.IMEM_LAT(IMEM_LAT), .CNT_W(CNT_W)) dut (
        .stg_clk (clk),
        .reset_n (rstN),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mkStim(input int idV, input int r1, input int u1,
                                     input int r2, input int u2, input int exV,
                                     input int rd, input int ld, input int br,
                                     input int ms, input int busy, input int clr);
        stim_t s;
        s.idValid  = 1'(idV);
        s.rs1      = 5'(r1);
        s.rs1Used  = 1'(u1);
        s.rs2      = 5'(r2);
        s.rs2Used  = 1'(u2);
        s.exValid  = 1'(exV);
        s.exRd     = 5'(rd);
        s.exLoad   = 1'(ld);
        s.exBranch = 1'(br);
        s.exMis    = 1'(ms);
        s.memBusy  = 1'(busy);
        s.perfClr  = 1'(clr);
        return s;
    endfunction

    task automatic addVec(input string n, input stim_t s, input logic [9:0] c,
                          input int st, input int fl);
        vec_t v;
        v.name  = n;
        v.s     = s;
        v.ctl   = c;
        v.stall = st;
        v.flush = fl;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input stim_t s);
        bus.id_valid      = s.idValid;
        bus.id_rs1        = s.rs1;
        bus.id_rs1_used   = s.rs1Used;
        bus.id_rs2        = s.rs2;
        bus.id_rs2_used   = s.rs2Used;
        bus.ex_valid      = s.exValid;
        bus.ex_rd         = s.exRd;
        bus.ex_rd_memory  = s.exLoad;
        bus.ex_is_branch  = s.exBranch;
        bus.ex_mispredict = s.exMis;
        bus.mem_busy      = s.memBusy;
        bus.perf_clr      = s.perfClr;
    endtask

    function automatic logic [9:0] actualCtl();
        return {bus.pc_ena, bus.pc_redirect,
                bus.fetch_stg_ena, bus.decode_stg_ena, bus.exec_stg_ena, bus.mem_stg_ena,
                bus.fetch_stg_x, bus.decode_stg_x, bus.exec_stg_x, bus.mem_stg_x};
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] expCtl);
        logic [9:0] act;
        act = actualCtl();
        total++;
        if (act !== expCtl) begin
            bad++;
            $display("[TB] FAIL %s ctl: got %b want %b", name, act, expCtl);
        end
    endtask

    task automatic checkCounts(input string name, input int s, input int f);
        logic [CNT_W-1:0] wantS;
        logic [CNT_W-1:0] wantF;
        wantS = CNT_W'(s);
        wantF = CNT_W'(f);
        total++;
        if (bus.stall_cnt !== wantS || bus.flush_cnt !== wantF) begin
            bad++;
            $display("[TB] FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, bus.stall_cnt, bus.flush_cnt, wantS, wantF);
        end
    endtask

    // Drive away from the edge, check controls, then let the edge happen
    task automatic runCycle(input string name, input stim_t s, input logic [9:0] expCtl);
        @(negedge clk);
        applyStimulus(s);
        #1;
        checkOutput(name, expCtl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        stim_t luS;
        stim_t misS;
        stim_t busyS;
        int    bubbles;
        logic  lu;
        logic  mis;
        logic [9:0] expCtl;
        int    modv;

        total = 0;
        bad   = 0;
        modv  = 1 << CNT_W;
        idleS = mkStim(0,0,0,0,0,0,0,0,0,0,0,0);
        luS   = mkStim(1,5,1,0,0,1,5,1,0,0,0,0);
        misS  = mkStim(0,0,0,0,0,1,0,0,1,1,0,0);
        busyS = mkStim(0,0,0,0,0,0,0,0,0,0,1,0);

        addVec("idle",          idleS,                            C_NORMAL, 0, 0);
        addVec("x0 load",       mkStim(1,0,1,0,0,1,0,1,0,0,0,0), C_NORMAL, 0, 0);
        addVec("unused ops",    mkStim(1,5,0,5,0,1,5,1,0,0,0,0), C_NORMAL, 0, 0);
        addVec("lu rs1",        luS,                              C_LU,     1, 0);
        addVec("after lu",      mkStim(1,5,1,0,0,0,5,1,0,0,0,0), C_NORMAL, 1, 0);
        addVec("lu rs2",        mkStim(1,3,0,7,1,1,7,1,0,0,0,0), C_LU,     2, 0);
        addVec("not a load",    mkStim(1,3,0,7,1,1,7,0,0,0,0,0), C_NORMAL, 2, 0);
        addVec("id invalid",    mkStim(0,3,0,7,1,1,7,1,0,0,0,0), C_NORMAL, 2, 0);
        addVec("mis",           misS,                             C_MIS,    2, 1);
        addVec("refill 1",      idleS,                            C_REFILL, 2, 1);
        addVec("refill lu ign", luS,                              C_REFILL, 2, 1);
        addVec("back to run",   idleS,                            C_NORMAL, 2, 1);
        addVec("mis and lu",    mkStim(1,5,1,0,0,1,5,1,1,1,0,0), C_MIS,    2, 2);
        addVec("refill a",      idleS,                            C_REFILL, 2, 2);
        addVec("refill b",      idleS,                            C_REFILL, 2, 2);
        addVec("branch ok",     mkStim(0,0,0,0,0,1,0,0,1,0,0,0), C_NORMAL, 2, 2);
        addVec("mis ex invalid",mkStim(0,0,0,0,0,0,0,0,1,1,0,0), C_NORMAL, 2, 2);
        addVec("busy with mis", mkStim(0,0,0,0,0,1,0,0,1,1,1,0), C_FREEZE, 3, 2);
        addVec("mis after busy",misS,                             C_MIS,    3, 3);
        addVec("refill c",      idleS,                            C_REFILL, 3, 3);
        addVec("mis in refill", misS,                             C_MIS,    3, 4);
        addVec("refill d",      idleS,                            C_REFILL, 3, 4);
        addVec("refill e",      idleS,                            C_REFILL, 3, 4);
        addVec("run again",     idleS,                            C_NORMAL, 3, 4);
        addVec("clr with lu",   mkStim(1,5,1,0,0,1,5,1,0,0,0,1), C_LU,     0, 0);
        addVec("lu after clr",  luS,                              C_LU,     1, 0);
        addVec("clr with mis",  mkStim(0,0,0,0,0,1,0,0,1,1,0,1), C_MIS,    0, 0);
        addVec("refill f",      idleS,                            C_REFILL, 0, 0);
        addVec("refill g",      idleS,                            C_REFILL, 0, 0);
        addVec("busy with lu",  mkStim(1,5,1,0,0,1,5,1,0,0,1,0), C_FREEZE, 1, 0);
        addVec("busy with clr", mkStim(0,0,0,0,0,0,0,0,0,0,1,1), C_FREEZE, 0, 0);

        rstN = 1'b0;
        applyStimulus(idleS);
        #2;
        checkOutput("reset forced", C_FREEZE);
        checkCounts("reset", 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;

        foreach (vecs[i]) begin
            runCycle(vecs[i].name, vecs[i].s, vecs[i].ctl);
            checkCounts(vecs[i].name, vecs[i].stall, vecs[i].flush);
        end
        expS = 0;
        expF = 0;

        // mem_busy lands on the first refill cycle and must not consume bubbles
        runCycle("freeze mis", misS, C_MIS);
        expF++;
        for (int i = 0; i < 4; i++) begin
            runCycle("freeze busy", busyS, C_FREEZE);
            expS++;
        end
        runCycle("freeze refill 1", idleS, C_REFILL);
        runCycle("freeze refill 2", idleS, C_REFILL);
        runCycle("freeze done", idleS, C_NORMAL);
        checkCounts("freeze counts", expS, expF);

        // Asynchronous reset while a refill is still pending
        runCycle("rst mis", misS, C_MIS);
        runCycle("rst refill", idleS, C_REFILL);
        @(negedge clk);
        applyStimulus(idleS);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rst async forced", C_FREEZE);
        checkCounts("rst async", 0, 0);
        applyStimulus(misS);
        #1;
        checkOutput("rst forced with mis", C_FREEZE);
        repeat (2) @(posedge clk);
        #1;
        checkCounts("rst held", 0, 0);
        @(negedge clk);
        applyStimulus(idleS);
        rstN = 1'b1;
        #1;
        checkOutput("rst released", C_NORMAL);
        @(posedge clk);
        #1;
        runCycle("rst no residual", idleS, C_NORMAL);
        checkCounts("rst after", 0, 0);
        expS = 0;
        expF = 0;

        // Randomized run against an event-level model of the controller
        bubbles = 0;
        for (int n = 0; n < 2000; n++) begin
            s.idValid  = ($urandom_range(0, 3) != 0);
            s.rs1      = 5'($urandom_range(0, 3));
            s.rs1Used  = 1'($urandom_range(0, 1));
            s.rs2      = 5'($urandom_range(0, 3));
            s.rs2Used  = 1'($urandom_range(0, 1));
            s.exValid  = ($urandom_range(0, 3) != 0);
            s.exRd     = 5'($urandom_range(0, 3));
            s.exLoad   = 1'($urandom_range(0, 1));
            s.exBranch = ($urandom_range(0, 2) == 0);
            s.exMis    = 1'($urandom_range(0, 1));
            s.memBusy  = ($urandom_range(0, 7) == 0);
            s.perfClr  = ($urandom_range(0, 63) == 0);

            mis = s.exValid && s.exBranch && s.exMis;
            lu  = s.exValid && s.exLoad && (s.exRd != 0) && s.idValid &&
                  ((s.rs1Used && s.rs1 == s.exRd) || (s.rs2Used && s.rs2 == s.exRd));

            if (s.memBusy) begin
                expCtl = C_FREEZE;
                expS   = expS + 1;
            end else if (mis) begin
                expCtl  = C_MIS;
                expF    = expF + 1;
                bubbles = IMEM_LAT - 1;
            end else if (bubbles > 0) begin
                expCtl  = C_REFILL;
                bubbles = bubbles - 1;
            end else if (lu) begin
                expCtl = C_LU;
                expS   = expS + 1;
            end else begin
                expCtl = C_NORMAL;
            end
            if (s.perfClr) begin
                expS = 0;
                expF = 0;
            end
            expS = expS % modv;
            expF = expF % modv;

            runCycle("random", s, expCtl);
            checkCounts("random", expS, expF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
